branch_ctrl: RTL and testbench

Sequencing controller for ID-stage control transfers in the pipelined MIPS core. It accepts the 4-bit branch command from the control unit and the two ID-stage operands, and stalls ID until forwarded operands are valid. It then resolves the branch condition, drives the PC-select mux with the redirect target, and flushes the wrong-path fetch slots. It also keeps a saturating count of taken transfers for performance monitoring.

---
 rtl/branch_ctrl.sv | 137 +++++++++++++
 tb/tb_branch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// ID-stage control-transfer sequencer: operand-wait stall, branch
// resolution, PC redirect, two-slot wrong-path flush, taken counter.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 brValid,
    input  logic [3:0]           brComm,
    input  logic [`WORD_LEN-1:0] reg1,
    input  logic [`WORD_LEN-1:0] reg2,
    input  logic                 operandsReady,
    input  logic [`WORD_LEN-1:0] brTarget,
    output logic                 stall,
    output logic                 pcSel,
    output logic [`WORD_LEN-1:0] pcTarget,
    output logic                 flush,
    output logic                 linkWrite,
    output logic [CNT_W-1:0]     takenCnt
);

    localparam logic [3:0] COND_BNE  = 4'b0001;
    localparam logic [3:0] COND_JUMP = 4'b0010;
    localparam logic [3:0] COND_BEQ  = 4'b0011;
    localparam logic [3:0] COND_JAL  = 4'b0100;
    localparam logic [3:0] COND_JR   = 4'b0101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REDIRECT,
        FLUSH2
    } state_t;

    state_t               state;
    logic                 isXfer;
    logic                 isTaken;
    logic                 isJal;
    logic                 goRedirect;
    logic [`WORD_LEN-1:0] resTarget;

    // Decode the command into transfer / taken / link / target.
    always_comb begin
        isXfer    = 1'b0;
        isTaken   = 1'b0;
        isJal     = 1'b0;
        resTarget = brTarget;
        case (brComm)
            COND_BNE: begin
                isXfer  = 1'b1;
                isTaken = (reg1 != reg2);
            end
            COND_BEQ: begin
                isXfer  = 1'b1;
                isTaken = (reg1 == reg2);
            end
            COND_JUMP: begin
                isXfer  = 1'b1;
                isTaken = 1'b1;
            end
            COND_JAL: begin
                isXfer  = 1'b1;
                isTaken = 1'b1;
                isJal   = 1'b1;
            end
            COND_JR: begin
                isXfer    = 1'b1;
                isTaken   = 1'b1;
                resTarget = reg1;
            end
            default: begin
                isXfer = 1'b0;
            end
        endcase
        isXfer = isXfer & brValid;
    end

    // Redirect fires on a taken resolution in IDLE or WAIT.
    always_comb begin
        goRedirect = 1'b0;
        if (state == IDLE || state == WAIT)
            goRedirect = isXfer & isTaken & operandsReady;
    end

    // Hold ID while a transfer waits on forwarded operands.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = isXfer & ~operandsReady;
            WAIT:    stall = ~operandsReady;
            default: stall = 1'b0;
        endcase
    end

    // State sequencing plus registered redirect/flush/link/counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pcSel     <= 1'b0;
            flush     <= 1'b0;
            linkWrite <= 1'b0;
            pcTarget  <= '0;
            takenCnt  <= '0;
        end else begin
            pcSel     <= goRedirect;
            flush     <= goRedirect | (state == REDIRECT);
            linkWrite <= goRedirect & isJal;
            if (goRedirect) begin
                pcTarget <= resTarget;
                if (takenCnt != {CNT_W{1'b1}})
                    takenCnt <= takenCnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (goRedirect)
                        state <= REDIRECT;
                    else if (isXfer && !operandsReady)
                        state <= WAIT;
                end
                WAIT: begin
                    if (goRedirect)
                        state <= REDIRECT;
                    else if (!brValid || operandsReady)
                        state <= IDLE;
                end
                REDIRECT: state <= FLUSH2;
                FLUSH2:   state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed plan steps then random transfers
// checked against a per-transfer behavioural model.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_branch_ctrl;

    typedef logic [`WORD_LEN-1:0] word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        brValid;
    logic [3:0]  brComm;
    word_t       reg1;
    word_t       reg2;
    logic        operandsReady;
    word_t       brTarget;

    logic        stall;
    logic        pcSel;
    word_t       pcTarget;
    logic        flush;
    logic        linkWrite;
    logic [15:0] takenCnt;

    logic        stall2;
    logic        pcSel2;
    word_t       pcTarget2;
    logic        flush2;
    logic        linkWrite2;
    logic [1:0]  takenCnt2;

    int          testCnt = 0;
    int          failCnt = 0;
    logic [15:0] cnt = '0;
    logic [1:0]  cnt2 = '0;
    word_t       lastT = '0;

    always #5 clk = ~clk;

    branch_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .brValid(brValid), .brComm(brComm),
        .reg1(reg1), .reg2(reg2),
        .operandsReady(operandsReady),
        .brTarget(brTarget),
        .stall(stall), .pcSel(pcSel),
        .pcTarget(pcTarget), .flush(flush),
        .linkWrite(linkWrite), .takenCnt(takenCnt)
    );

    branch_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .brValid(brValid), .brComm(brComm),
        .reg1(reg1), .reg2(reg2),
        .operandsReady(operandsReady),
        .brTarget(brTarget),
        .stall(stall2), .pcSel(pcSel2),
        .pcTarget(pcTarget2), .flush(flush2),
        .linkWrite(linkWrite2), .takenCnt(takenCnt2)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: present one transfer, wait waitN cycles on operands,
    // then check resolution and any redirect/flush sequence.
    // Entered and left just after a rising edge.
    task automatic xfer(input logic [3:0] cmd,
                        input word_t r1,
                        input word_t r2,
                        input word_t tgt,
                        input int waitN);
        bit    isX;
        bit    tk;
        word_t expT;
        isX  = (cmd >= 4'd1 && cmd <= 4'd5);
        tk   = 1'b0;
        if (cmd == 4'd3) tk = (r1 == r2);
        if (cmd == 4'd1) tk = (r1 != r2);
        if (cmd == 4'd2 || cmd == 4'd4 || cmd == 4'd5) tk = 1'b1;
        expT = (cmd == 4'd5) ? r1 : tgt;
        brValid  = 1'b1;
        brComm   = cmd;
        reg1     = r1;
        reg2     = r2;
        brTarget = tgt;
        for (int i = 0; i < waitN; i++) begin
            operandsReady = 1'b0;
            @(negedge clk);
            chk("waitStall", stall, isX);
            chk("waitPcSel", pcSel, 0);
            @(posedge clk); #1;
        end
        operandsReady = 1'b1;
        @(negedge clk);
        chk("resStall", stall, 0);
        chk("resPcSel", pcSel, 0);
        chk("resFlush", flush, 0);
        chk("resTarget", pcTarget, lastT);
        chk("resCnt", takenCnt, cnt);
        chk("resCnt2", takenCnt2, cnt2);
        @(posedge clk); #1;
        if (!(isX && tk)) begin
            brValid = 1'b0;
            return;
        end
        cnt   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        cnt2  = (cnt2 == 2'd3) ? cnt2 : cnt2 + 2'd1;
        lastT = expT;
        // wrong-path transfer that would stall if it were seen
        brValid       = 1'b1;
        brComm        = 4'd3;
        reg2          = reg1;
        operandsReady = 1'b0;
        @(negedge clk);
        chk("rdPcSel", pcSel, 1);
        chk("rdFlush", flush, 1);
        chk("rdTarget", pcTarget, expT);
        chk("rdLink", linkWrite, (cmd == 4'd4));
        chk("rdStall", stall, 0);
        chk("rdCnt", takenCnt, cnt);
        chk("rdCnt2", takenCnt2, cnt2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("f2PcSel", pcSel, 0);
        chk("f2Flush", flush, 1);
        chk("f2Link", linkWrite, 0);
        chk("f2Stall", stall, 0);
        @(posedge clk); #1;
        brValid       = 1'b0;
        operandsReady = 1'b1;
    endtask

    initial begin
        logic [3:0] cmds [8];
        word_t      a;
        word_t      b;
        cmds = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd6, 4'd15};

        rst           = 1'b1;
        brValid       = 1'b0;
        brComm        = 4'd0;
        reg1          = '0;
        reg2          = '0;
        operandsReady = 1'b1;
        brTarget      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstStall", stall, 0);
        chk("rstPcSel", pcSel, 0);
        chk("rstFlush", flush, 0);
        chk("rstLink", linkWrite, 0);
        chk("rstTarget", pcTarget, 0);
        chk("rstCnt", takenCnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // BEQ equal, BNE equal, BEQ with 2-cycle wait
        xfer(4'd3, 32'h5, 32'h5, 32'h40, 0);
        xfer(4'd1, 32'h7, 32'h7, 32'h80, 0);
        xfer(4'd3, 32'h3, 32'h3, 32'h44, 2);
        // JR, JAL, then the same transfer on first IDLE cycle
        xfer(4'd5, 32'h400, 32'h1, 32'h999, 0);
        xfer(4'd4, 32'h9, 32'h8, 32'h100, 0);
        xfer(4'd3, 32'h6, 32'h6, 32'h48, 0);
        // non-transfer code with brValid
        xfer(4'd6, 32'h1, 32'h2, 32'h50, 1);

        // reset asserted during REDIRECT
        brValid       = 1'b1;
        brComm        = 4'd2;
        brTarget      = 32'h200;
        operandsReady = 1'b1;
        @(posedge clk); #1;
        brValid = 1'b0;
        @(negedge clk);
        chk("preRstPcSel", pcSel, 1);
        #1 rst = 1'b1;
        #1;
        chk("midRstPcSel", pcSel, 0);
        chk("midRstFlush", flush, 0);
        chk("midRstCnt", takenCnt, 0);
        chk("midRstTarget", pcTarget, 0);
        cnt   = '0;
        cnt2  = '0;
        lastT = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // small counter saturates at 3
        for (int i = 0; i < 4; i++)
            xfer(4'd2, 32'h0, 32'h0, 32'h300 + i, 0);
        xfer(4'd6, 32'h0, 32'h0, 32'h0, 0);

        // upstream kill while waiting
        brValid       = 1'b1;
        brComm        = 4'd3;
        reg1          = 32'h11;
        reg2          = 32'h11;
        operandsReady = 1'b0;
        @(negedge clk);
        chk("killWaitStall", stall, 1);
        @(posedge clk); #1;
        brValid       = 1'b0;
        operandsReady = 1'b1;
        @(negedge clk);
        chk("killStall", stall, 0);
        @(posedge clk); #1;
        xfer(4'd1, 32'h1, 32'h2, 32'h600, 0);

        // random transfers
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? a : $urandom;
            xfer(cmds[$urandom_range(0, 7)], a, b,
                 $urandom, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
